router_n_top: RTL and testbench
===============================

Name: router_n_top

Overview:
- Parametrised successor of the 3-port byte router: one input packet stream is steered to one of NUM_PORTS output FIFOs by the address field in the header byte.
- Adds parametrised data width, port count and FIFO depth, defined handling of illegal addresses, and full-FIFO back-pressure.
- Contains an input FSM, a per-packet parity checker and NUM_PORTS synchronous FIFOs. Sits between the upstream packet source and the per-port readers.

Parameters:
- NUM_PORTS, 3: number of output ports (2..16).
- DATA_W, 8: byte width. Must exceed ADDR_W.
- FIFO_DEPTH, 16: entries per output FIFO (power of 2).
- TIMEOUT, 30: idle cycles before an unread FIFO is flushed (used only with the optional feature).
- ADDR_W, $clog2(NUM_PORTS): derived; header address field width.

Ports:
- clk  in  1  rising-edge clock.
- resetn  in  1  asynchronous active-low reset.
- packet_valid  in  1  high for header and payload bytes; low in the cycle the parity byte is presented.
- datain  in  DATA_W  input byte. Header layout: [ADDR_W-1:0] = address, remaining bits = length (informational).
- read_enb  in  NUM_PORTS  per-port read request.
- vld_out  out  NUM_PORTS  per-port FIFO not-empty.
- data_out  out  NUM_PORTS*DATA_W  flattened, registered read data; port p occupies bits [p*DATA_W +: DATA_W].
- busy  out  1  input stall; upstream holds datain and packet_valid while busy=1.
- err  out  1  packet error flag (parity mismatch or illegal address).

Behaviour:
- Reset (async, resetn=0): FSM goes to DECODE; all FIFO pointers and counts are cleared; vld_out=0, data_out=0, busy=0, err=0, parity accumulator=0.
- Accept rule: a byte is consumed at a rising edge only when busy=0 and the FSM is in a consuming state.
- DECODE (busy=0):
  - On packet_valid=1, latch addr = datain[ADDR_W-1:0].
  - addr >= NUM_PORTS: go to DROP.
  - Target FIFO empty: write header, parity = header, go to LOAD.
  - Target FIFO not empty: latch header, go to WAIT_EMPTY.
- WAIT_EMPTY (busy=1): when the target FIFO is empty, write the latched header, parity = header, go to LOAD.
- LOAD:
  - busy = full[target].
  - packet_valid=1 and not full: write byte, parity ^= byte.
  - packet_valid=0 and not full: write the byte (parity byte), latch it as rx_parity, go to CHECK.
- CHECK (busy=1, one cycle): err <= (parity != rx_parity); go to DECODE.
- DROP (busy=0): discard bytes while packet_valid=1. On the first packet_valid=0 cycle, discard that byte, set err=1 and go to DECODE.
- err: holds until the next legal header is accepted in DECODE, then clears in that cycle.
- FIFO write/read:
  - A write to a full FIFO cannot occur (the FSM stalls instead).
  - read_enb[p] with empty=0: data_out[p] <= head entry at the next edge, rd_ptr advances.
  - read_enb[p] on an empty FIFO: no effect; data_out[p] holds.
  - Simultaneous read and write on the same FIFO in one cycle: both take effect, count unchanged.
  - vld_out[p] = ~empty[p] (combinational from count).
- Latency: a header written at edge N gives vld_out=1 after edge N; asserting read_enb in cycle N+1 gives data_out valid after edge N+2.
- Pointers wrap modulo FIFO_DEPTH. The count is ADDR_W-independent, $clog2(FIFO_DEPTH)+1 bits wide.
- Illegal addresses never write any FIFO.

Optional Feature:
- Macro: ROUTER_N_TIMEOUT_FLUSH_EN.
- Defined:
  - Per-port counter increments while vld_out[p]=1 and read_enb[p]=0, and clears on read_enb[p]=1 or when empty.
  - When the counter reaches TIMEOUT, FIFO p is flushed: pointers and count go to 0, data_out[p] is unchanged, counter clears.
  - If p is the current target in WAIT_EMPTY or LOAD, the FSM goes to DROP for the remainder of the packet and err is set when DROP exits.
- Undefined: no counters; an unread FIFO stalls the input indefinitely via busy.

Test Plan:
1. Reset: hold resetn=0 mid-packet, release -> vld_out=0, data_out=0, busy=0, err=0; a following packet routes correctly.
2. Legal packet (NUM_PORTS=3, DATA_W=8): bytes 0x0D,0x11,0x22,0x33 with packet_valid=1, then parity 0x0D with packet_valid=0 -> vld_out=3'b010; five reads return 0D,11,22,33,0D; err=0; busy=1 only in the CHECK cycle.
3. Bad parity: same packet with parity 0x00 -> err=1 after CHECK; err clears when the next legal header is accepted.
4. Back-pressure (FIFO_DEPTH=16): 20-byte packet to port 0 with no reads -> busy=1 after the 16th write and datain held; one read of port 0 -> busy=0 for one accepted byte; no byte lost or duplicated.
5. Illegal address: header 0x07 (addr 3), 2 payload bytes, parity -> busy stays 0, vld_out stays 0, err=1 after the parity cycle.
6. Timeout flush (macro defined, TIMEOUT=30): packet to port 2, never read -> vld_out[2] drops exactly 30 cycles after first going high; next packet is accepted normally.

Source files
------------

// File: rtl/router_n_top.sv
// router_n_top: steers one packet stream into NUM_PORTS output FIFOs using the header address.
// Optional: define ROUTER_N_TIMEOUT_FLUSH_EN to flush any FIFO left unread for TIMEOUT cycles.
module router_n_top #(
  parameter int  NUM_PORTS  = 3,
  parameter int  DATA_W     = 8,
  parameter int  FIFO_DEPTH = 16,
  parameter int  TIMEOUT    = 30,
  localparam int ADDR_W     = $clog2(NUM_PORTS)
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        packet_valid,
  input  logic [DATA_W-1:0]           datain,
  input  logic [NUM_PORTS-1:0]        read_enb,
  output logic [NUM_PORTS-1:0]        vld_out,
  output logic [NUM_PORTS*DATA_W-1:0] data_out,
  output logic                        busy,
  output logic                        err
);

  localparam int               PTR_W    = $clog2(FIFO_DEPTH);
  localparam int               CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  if (TIMEOUT < 1 || DATA_W <= ADDR_W) begin : g_param_check
    $error("router_n_top: illegal parameter set");
  end

  typedef enum logic [2:0] {DECODE, WAIT_EMPTY, LOAD, CHECK, DROP} state_t;

  state_t              state, state_d;
  logic [ADDR_W-1:0]   target, target_d, wr_port, hdr_addr;
  logic [DATA_W-1:0]   hdr_q, hdr_d, parity, parity_d, rx_parity, rx_parity_d, wr_data;
  logic                err_d, wr_go, hdr_legal;
  logic [NUM_PORTS-1:0] empty, full, flush;

  assign hdr_addr  = datain[ADDR_W-1:0];
  assign hdr_legal = int'(hdr_addr) < NUM_PORTS;
  assign vld_out   = ~empty;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state;
    target_d    = target;
    hdr_d       = hdr_q;
    parity_d    = parity;
    rx_parity_d = rx_parity;
    err_d       = err;
    busy        = 1'b0;
    wr_go       = 1'b0;
    wr_port     = target;
    wr_data     = datain;
    unique case (state)
      DECODE: begin
        if (packet_valid) begin
          if (!hdr_legal) begin
            state_d = DROP;
          end else begin
            err_d    = 1'b0;
            target_d = hdr_addr;
            wr_port  = hdr_addr;
            if (empty[hdr_addr]) begin
              wr_go    = 1'b1;
              parity_d = datain;
              state_d  = LOAD;
            end else begin
              hdr_d   = datain;
              state_d = WAIT_EMPTY;
            end
          end
        end
      end
      WAIT_EMPTY: begin
        busy = 1'b1;
        if (flush[target]) begin
          state_d = DROP;
        end else if (empty[target]) begin
          wr_go    = 1'b1;
          wr_data  = hdr_q;
          parity_d = hdr_q;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        busy = full[target];
        if (flush[target]) begin
          // A flush that lands on the parity byte ends the packet here instead of in DROP.
          if (!full[target] && !packet_valid) begin
            err_d   = 1'b1;
            state_d = DECODE;
          end else begin
            state_d = DROP;
          end
        end else if (!full[target]) begin
          wr_go = 1'b1;
          if (packet_valid) begin
            parity_d = parity ^ datain;
          end else begin
            rx_parity_d = datain;
            state_d     = CHECK;
          end
        end
      end
      CHECK: begin
        busy    = 1'b1;
        err_d   = (parity != rx_parity);
        state_d = DECODE;
      end
      DROP: begin
        if (!packet_valid) begin
          err_d   = 1'b1;
          state_d = DECODE;
        end
      end
      default: state_d = DECODE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop updates together at the edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= DECODE;
      target    <= '0;
      hdr_q     <= '0;
      parity    <= '0;
      rx_parity <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_d;
      target    <= target_d;
      hdr_q     <= hdr_d;
      parity    <= parity_d;
      rx_parity <= rx_parity_d;
      err       <= err_d;
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rd_q;
    logic              wr_p, rd_p;

    assign wr_p     = wr_go && (wr_port == ADDR_W'(p));
    assign rd_p     = read_enb[p] && !empty[p];
    assign empty[p] = (cnt == '0);
    assign full[p]  = (cnt == FULL_CNT);
    assign data_out[p*DATA_W +: DATA_W] = rd_q;

    // NOTE: storage has no reset; the pointers and count alone say which entries are valid.
    always_ff @(posedge clk) begin
      if (wr_p) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
        rd_q   <= '0;
      end else begin
        if (rd_p) rd_q <= mem[rd_ptr];
        if (flush[p]) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          cnt    <= '0;
        end else begin
          if (wr_p) wr_ptr <= wr_ptr + PTR_W'(1);
          if (rd_p) rd_ptr <= rd_ptr + PTR_W'(1);
          if (wr_p && !rd_p)      cnt <= cnt + CNT_W'(1);
          else if (rd_p && !wr_p) cnt <= cnt - CNT_W'(1);
        end
      end
    end

`ifdef ROUTER_N_TIMEOUT_FLUSH_EN
    localparam int              TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    logic [TO_W-1:0] idle_cnt;

    // The flush fires on the edge where the idle count would reach TIMEOUT.
    assign flush[p] = !empty[p] && !read_enb[p] && (idle_cnt == TO_LAST);

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        idle_cnt <= '0;
      end else if (empty[p] || read_enb[p] || flush[p]) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + TO_W'(1);
      end
    end
`else
    assign flush[p] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_router_n_top.sv
// tb_router_n_top: directed vector table plus hand sequences for reset, back-pressure and flush.
module tb_router_n_top;

  logic        clk = 1'b0;
  logic        resetn, packet_valid, busy, err;
  logic [7:0]  datain;
  logic [2:0]  read_enb, vld_out;
  logic [23:0] data_out;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        pv;
    logic [7:0]  d;
    logic [2:0]  re;
    logic [2:0]  vld;
    logic        bsy;
    logic        er;
    logic [23:0] dout;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] bp [20];
  logic [7:0] got[$];
  logic [7:0] par;
  int         idx, cyc, stalls, high;
  logic       acc, rd_pending;

  always #5 clk = ~clk;

  router_n_top #(
    .NUM_PORTS (3),
    .DATA_W    (8),
    .FIFO_DEPTH(16),
    .TIMEOUT   (30)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .packet_valid(packet_valid),
    .datain      (datain),
    .read_enb    (read_enb),
    .vld_out     (vld_out),
    .data_out    (data_out),
    .busy        (busy),
    .err         (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic pv, input logic [7:0] d, input logic [2:0] re,
                     input logic [2:0] vld, input logic bsy, input logic er, input logic [23:0] dout);
    vec_t v;
    v.pv = pv; v.d = d; v.re = re; v.vld = vld; v.bsy = bsy; v.er = er; v.dout = dout;
    vecs.push_back(v);
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    // pv, datain, read_enb | vld_out, busy, err, data_out (state after the edge)
    // Legal packet to port 1, then drain it.
    add(1, 8'h0D, 3'b000, 3'b010, 0, 0, 24'h000000);
    add(1, 8'h11, 3'b000, 3'b010, 0, 0, 24'h000000);
    add(1, 8'h22, 3'b000, 3'b010, 0, 0, 24'h000000);
    add(1, 8'h33, 3'b000, 3'b010, 0, 0, 24'h000000);
    add(0, 8'h0D, 3'b000, 3'b010, 1, 0, 24'h000000);
    add(0, 8'h00, 3'b010, 3'b010, 0, 0, 24'h000D00);
    add(0, 8'h00, 3'b010, 3'b010, 0, 0, 24'h001100);
    add(0, 8'h00, 3'b010, 3'b010, 0, 0, 24'h002200);
    add(0, 8'h00, 3'b010, 3'b010, 0, 0, 24'h003300);
    add(0, 8'h00, 3'b010, 3'b000, 0, 0, 24'h000D00);
    add(0, 8'h00, 3'b010, 3'b000, 0, 0, 24'h000D00);
    // Bad parity, then a legal header to port 0 clears err.
    add(1, 8'h0D, 3'b000, 3'b010, 0, 0, 24'h000D00);
    add(1, 8'h11, 3'b000, 3'b010, 0, 0, 24'h000D00);
    add(1, 8'h22, 3'b000, 3'b010, 0, 0, 24'h000D00);
    add(1, 8'h33, 3'b000, 3'b010, 0, 0, 24'h000D00);
    add(0, 8'h00, 3'b000, 3'b010, 1, 0, 24'h000D00);
    add(0, 8'h00, 3'b000, 3'b010, 0, 1, 24'h000D00);
    add(1, 8'h04, 3'b000, 3'b011, 0, 0, 24'h000D00);
    add(1, 8'hAA, 3'b000, 3'b011, 0, 0, 24'h000D00);
    add(0, 8'hAE, 3'b000, 3'b011, 1, 0, 24'h000D00);
    add(0, 8'h00, 3'b000, 3'b011, 0, 0, 24'h000D00);
    add(0, 8'h00, 3'b011, 3'b011, 0, 0, 24'h000D04);
    add(0, 8'h00, 3'b011, 3'b011, 0, 0, 24'h0011AA);
    add(0, 8'h00, 3'b011, 3'b010, 0, 0, 24'h0022AE);
    add(0, 8'h00, 3'b011, 3'b010, 0, 0, 24'h0033AE);
    add(0, 8'h00, 3'b010, 3'b000, 0, 0, 24'h0000AE);
    // Illegal address 3: dropped, err after the parity cycle, cleared by the next legal header.
    add(1, 8'h07, 3'b000, 3'b000, 0, 0, 24'h0000AE);
    add(1, 8'h55, 3'b000, 3'b000, 0, 0, 24'h0000AE);
    add(1, 8'h66, 3'b000, 3'b000, 0, 0, 24'h0000AE);
    add(0, 8'h34, 3'b000, 3'b000, 0, 1, 24'h0000AE);
    add(0, 8'h00, 3'b000, 3'b000, 0, 1, 24'h0000AE);
    add(1, 8'h02, 3'b000, 3'b100, 0, 0, 24'h0000AE);
    add(0, 8'h02, 3'b000, 3'b100, 1, 0, 24'h0000AE);
    add(0, 8'h00, 3'b000, 3'b100, 0, 0, 24'h0000AE);
    add(0, 8'h00, 3'b100, 3'b100, 0, 0, 24'h0200AE);
    add(0, 8'h00, 3'b100, 3'b000, 0, 0, 24'h0200AE);
    // Simultaneous read and write on port 0.
    add(1, 8'h00, 3'b000, 3'b001, 0, 0, 24'h0200AE);
    add(1, 8'h5A, 3'b001, 3'b001, 0, 0, 24'h020000);
    add(0, 8'h5A, 3'b001, 3'b001, 1, 0, 24'h02005A);
    add(0, 8'h00, 3'b001, 3'b000, 0, 0, 24'h02005A);
    // Header to a non-empty port waits until the reader drains it.
    add(1, 8'h01, 3'b000, 3'b010, 0, 0, 24'h02005A);
    add(0, 8'h01, 3'b000, 3'b010, 1, 0, 24'h02005A);
    add(0, 8'h00, 3'b000, 3'b010, 0, 0, 24'h02005A);
    add(1, 8'h05, 3'b000, 3'b010, 1, 0, 24'h02005A);
    add(1, 8'h77, 3'b010, 3'b010, 1, 0, 24'h02015A);
    add(1, 8'h77, 3'b010, 3'b000, 1, 0, 24'h02015A);
    add(1, 8'h77, 3'b000, 3'b010, 0, 0, 24'h02015A);
    add(1, 8'h77, 3'b000, 3'b010, 0, 0, 24'h02015A);
    add(0, 8'h72, 3'b000, 3'b010, 1, 0, 24'h02015A);
    add(0, 8'h00, 3'b000, 3'b010, 0, 0, 24'h02015A);
    add(0, 8'h00, 3'b010, 3'b010, 0, 0, 24'h02055A);
    add(0, 8'h00, 3'b010, 3'b010, 0, 0, 24'h02775A);
    add(0, 8'h00, 3'b010, 3'b000, 0, 0, 24'h02725A);

    // Reset state, then a reset asserted in the middle of a packet.
    resetn = 1'b0; packet_valid = 1'b0; datain = '0; read_enb = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_state", {vld_out, busy, err, data_out}, '0);
    @(negedge clk);
    resetn = 1'b1;
    packet_valid = 1'b1; datain = 8'h0D; cycle();
    datain = 8'h11; read_enb = 3'b010; cycle();
    check("pre_reset_out", {vld_out, data_out}, {3'b010, 24'h000D00});
    datain = 8'h22; read_enb = '0;
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    check("midpkt_reset", {vld_out, busy, err, data_out}, '0);
    @(negedge clk);
    resetn = 1'b1; packet_valid = 1'b0; datain = '0;

    foreach (vecs[i]) begin
      packet_valid = vecs[i].pv;
      datain       = vecs[i].d;
      read_enb     = vecs[i].re;
      cycle();
      check($sformatf("vec%0d", i), {3'b000, vld_out, busy, err, data_out},
            {3'b000, vecs[i].vld, vecs[i].bsy, vecs[i].er, vecs[i].dout});
    end

    // Back-pressure: 20-byte packet to port 0 into a 16-entry FIFO.
    bp[0] = 8'h50;
    par   = bp[0];
    for (int i = 1; i < 19; i++) begin
      bp[i] = 8'(i * 7 + 3);
      par   = par ^ bp[i];
    end
    bp[19] = par;
    stalls = 0;
    read_enb = '0;
    for (int i = 0; i < 16; i++) begin
      packet_valid = 1'b1; datain = bp[i];
      #1;
      if (busy) stalls++;
      cycle();
    end
    check("bp_no_stall_16", stalls, 0);
    packet_valid = 1'b1; datain = bp[16];
    #1;
    check("bp_full_busy", busy, 1'b1);
    check("bp_full_vld", vld_out, 3'b001);
    repeat (2) begin
      cycle();
      #1;
      check("bp_hold_busy", busy, 1'b1);
    end
    read_enb = 3'b001;
    cycle();
    read_enb = '0;
    #1;
    check("bp_read_data", data_out[7:0], bp[0]);
    check("bp_read_unstall", busy, 1'b0);
    got.push_back(data_out[7:0]);
    cycle();
    datain = bp[17];
    #1;
    check("bp_refull_busy", busy, 1'b1);
    idx = 17; cyc = 0; rd_pending = 1'b0;
    do begin
      @(negedge clk);
      if (rd_pending) got.push_back(data_out[7:0]);
      read_enb     = 3'b001;
      packet_valid = (idx < 19);
      datain       = (idx < 20) ? bp[idx] : 8'h00;
      #1;
      acc        = (idx < 20) && !busy;
      rd_pending = vld_out[0];
      @(posedge clk);
      if (acc) idx++;
      cyc++;
    end while ((idx < 20 || rd_pending) && cyc < 200);
    @(negedge clk);
    read_enb = '0; packet_valid = 1'b0; datain = '0;
    check("bp_loop_bound", {31'd0, cyc < 200}, 1);
    check("bp_count", got.size(), 20);
    for (int i = 0; i < 20; i++) begin
      if (i < got.size()) check($sformatf("bp_byte%0d", i), got[i], bp[i]);
    end
    cycle();
    check("bp_end_state", {vld_out, busy, err}, 5'b00000);

`ifdef ROUTER_N_TIMEOUT_FLUSH_EN
    // Unread packet to port 2 is flushed exactly TIMEOUT cycles after vld_out rises.
    packet_valid = 1'b1; datain = 8'h02; read_enb = '0;
    @(posedge clk);
    high = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!vld_out[2]) break;
      high++;
      case (c)
        0:       begin packet_valid = 1'b1; datain = 8'h10; end
        1:       begin packet_valid = 1'b0; datain = 8'h12; end
        default: begin packet_valid = 1'b0; datain = 8'h00; end
      endcase
    end
    check("to_vld_cycles", high, 30);
    check("to_dout_kept", data_out[23:16], 8'h02);
    packet_valid = 1'b0; datain = '0;
    cycle();
    packet_valid = 1'b1; datain = 8'h01; cycle();
    packet_valid = 1'b0; datain = 8'h01; cycle();
    datain = '0; cycle();
    check("to_next_pkt", {vld_out, busy, err}, {3'b010, 1'b0, 1'b0});
    read_enb = 3'b010; cycle(); cycle();
    read_enb = '0;
    check("to_next_data", {vld_out, data_out[15:8]}, {3'b000, 8'h01});
`else
    // Without the flush feature an unread FIFO stays valid indefinitely.
    packet_valid = 1'b1; datain = 8'h02; read_enb = '0; cycle();
    packet_valid = 1'b0; datain = 8'h02; cycle();
    datain = '0;
    repeat (40) cycle();
    check("nt_hold_vld", {vld_out, err}, {3'b100, 1'b0});
    read_enb = 3'b100; cycle(); cycle();
    read_enb = '0;
    check("nt_drain", {vld_out, data_out[23:16]}, {3'b000, 8'h02});
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
